btn_debounce: RTL and testbench

- Conditions the five raw push-button inputs before they reach the cursor-control and button-input stages of the LCD calculator.
- Each button gets a two-flop synchroniser and a per-button stable-time debouncer.
- Outputs are a clean level, a one-cycle press pulse and a one-cycle release pulse per button.
- Direction buttons can auto-repeat press pulses while held, so the cursor keeps moving.

---
 rtl/btn_debounce.sv | 141 ++++++++++++++
 tb/tb_btn_debounce.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: per-button two-flop synchroniser, stable-time debouncer,
// registered level/press/release outputs and optional auto-repeat of press pulses.
module btn_debounce #(
  parameter int                N_BTN           = 5,
  parameter int                DEBOUNCE_CYC    = 330000,
  parameter int                REPEAT_DLY_CYC  = 16500000,
  parameter int                REPEAT_RATE_CYC = 3300000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 5'b01111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int DB_W    = ($clog2(DEBOUNCE_CYC) < 1) ? 1 : $clog2(DEBOUNCE_CYC);
  localparam int REP_MAX = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ? REPEAT_DLY_CYC : REPEAT_RATE_CYC;
  localparam int REP_W   = ($clog2(REP_MAX) < 1) ? 1 : $clog2(REP_MAX);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REPEAT_DLY_CYC - 1);
  localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             rise;
    logic             fall;
    logic             rep_fire;
    rep_state_t       state;
    rep_state_t       state_nx;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nx;

    // stable is the debounced level one cycle ahead of the registered output
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        stable <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync1 <= btn_raw[i];
        sync2 <= sync1;
        if (sync2 == stable) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    assign rise = stable & ~level_q;
    assign fall = ~stable & level_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= IDLE;
        rep_cnt <= '0;
      end else begin
        state   <= state_nx;
        rep_cnt <= rep_cnt_nx;
      end
    end

    // a debounced fall always wins over a repeat pulse due in the same cycle
    always_comb begin
      state_nx   = state;
      rep_cnt_nx = rep_cnt;
      rep_fire   = 1'b0;
      case (state)
        IDLE: begin
          if (rise && REPEAT_MASK[i]) begin
            state_nx   = DELAY;
            rep_cnt_nx = '0;
          end
        end
        DELAY: begin
          if (fall) begin
            state_nx   = IDLE;
            rep_cnt_nx = '0;
          end else if (rep_cnt == DLY_LAST) begin
            state_nx   = REPEAT;
            rep_cnt_nx = '0;
            rep_fire   = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (fall) begin
            state_nx   = IDLE;
            rep_cnt_nx = '0;
          end else if (rep_cnt == RATE_LAST) begin
            rep_cnt_nx = '0;
            rep_fire   = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + 1'b1;
          end
        end
        default: begin
          state_nx   = IDLE;
          rep_cnt_nx = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        level_q   <= stable;
        press_q   <= rise | rep_fire;
        release_q <= fall;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short debounce/repeat times; every cycle of
// each scenario is compared against hand-filled expectation tables.
module tb_btn_debounce;

  localparam int N_BTN = 5;
  localparam int MAX_T = 100;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  int check_count;
  int error_count;

  logic             rst_tab [0:MAX_T-1];
  logic [N_BTN-1:0] raw_tab [0:MAX_T-1];
  logic [N_BTN-1:0] lvl_tab [0:MAX_T-1];
  logic [N_BTN-1:0] prs_tab [0:MAX_T-1];
  logic [N_BTN-1:0] rel_tab [0:MAX_T-1];

  btn_debounce #(
    .N_BTN(N_BTN),
    .DEBOUNCE_CYC(4),
    .REPEAT_DLY_CYC(20),
    .REPEAT_RATE_CYC(8),
    .REPEAT_MASK(5'b01111)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N_BTN-1:0] observed,
                             input logic [N_BTN-1:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s got %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic clearTables();
    for (int t = 0; t < MAX_T; t++) begin
      rst_tab[t] = 1'b1;
      raw_tab[t] = '0;
      lvl_tab[t] = '0;
      prs_tab[t] = '0;
      rel_tab[t] = '0;
    end
  endtask

  task automatic setRaw(input int from, input int to, input logic [N_BTN-1:0] v);
    for (int t = from; t <= to; t++) raw_tab[t] = v;
  endtask

  task automatic setLevel(input int from, input int to, input logic [N_BTN-1:0] v);
    for (int t = from; t <= to; t++) lvl_tab[t] = v;
  endtask

  task automatic resetDut();
    rst_n   = 1'b0;
    btn_raw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset level", btn_level, '0);
    checkOutput("reset press", btn_press, '0);
    checkOutput("reset release", btn_release, '0);
  endtask

  // entry t of each table is driven before rising edge t and checked after it
  task automatic applyStimulus(input string name, input int len);
    for (int t = 0; t < len; t++) begin
      rst_n   = rst_tab[t];
      btn_raw = raw_tab[t];
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s level t=%0d", name, t), btn_level, lvl_tab[t]);
      checkOutput($sformatf("%s press t=%0d", name, t), btn_press, prs_tab[t]);
      checkOutput($sformatf("%s release t=%0d", name, t), btn_release, rel_tab[t]);
    end
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst_n       = 1'b0;
    btn_raw     = '0;

    // clean press on up, with repeats, then release
    resetDut();
    clearTables();
    setRaw(0, 49, 5'b00001);
    setLevel(6, 55, 5'b00001);
    prs_tab[6]  = 5'b00001;
    prs_tab[26] = 5'b00001;
    prs_tab[34] = 5'b00001;
    prs_tab[42] = 5'b00001;
    prs_tab[50] = 5'b00001;
    rel_tab[56] = 5'b00001;
    applyStimulus("clean", 60);

    // bounce on center shorter than the debounce time
    resetDut();
    clearTables();
    setRaw(0, 1, 5'b10000);
    setRaw(4, 5, 5'b10000);
    applyStimulus("bounce", 20);

    // center press and release, no repeat
    resetDut();
    clearTables();
    setRaw(0, 39, 5'b10000);
    setLevel(6, 45, 5'b10000);
    prs_tab[6]  = 5'b10000;
    rel_tab[46] = 5'b10000;
    applyStimulus("center", 60);

    // left released during repeat; the repeat due at 34 is suppressed, re-press restarts delay
    resetDut();
    clearTables();
    setRaw(0, 27, 5'b00100);
    setLevel(6, 33, 5'b00100);
    prs_tab[6]  = 5'b00100;
    prs_tab[26] = 5'b00100;
    rel_tab[34] = 5'b00100;
    setRaw(41, 76, 5'b00100);
    setLevel(47, 76, 5'b00100);
    prs_tab[47] = 5'b00100;
    prs_tab[67] = 5'b00100;
    prs_tab[75] = 5'b00100;
    applyStimulus("relrep", 77);

    // up and down together
    resetDut();
    clearTables();
    setRaw(0, 39, 5'b00011);
    setLevel(6, 39, 5'b00011);
    prs_tab[6]  = 5'b00011;
    prs_tab[26] = 5'b00011;
    prs_tab[34] = 5'b00011;
    applyStimulus("simul", 40);

    // reset asserted for edges 15..17 while down stays held
    resetDut();
    clearTables();
    setRaw(0, 53, 5'b00010);
    for (int t = 15; t <= 17; t++) rst_tab[t] = 1'b0;
    setLevel(6, 14, 5'b00010);
    setLevel(24, 53, 5'b00010);
    prs_tab[6]  = 5'b00010;
    prs_tab[24] = 5'b00010;
    prs_tab[44] = 5'b00010;
    prs_tab[52] = 5'b00010;
    applyStimulus("midrst", 54);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
